// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic result collector.
package systolic_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int row_w(input int n_size, input int datawidth);
    return n_size * 2 * datawidth;
  endfunction

  function automatic int idx_w(input int n_size);
    return (n_size > 1) ? $clog2(n_size) : 1;
  endfunction

  // MSB position of element k in a row; column 0 occupies the top bits.
  function automatic int elem_msb(input int k, input int n_size, input int datawidth);
    return (n_size - k) * 2 * datawidth - 1;
  endfunction

endpackage

// File: rtl/collector_bank.sv
// One matrix bank: row register file with a single write port and a registered read port.
module collector_bank
  import systolic_pkg::*;
#(
  parameter int ROW_W = 160,
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [ROW_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [ROW_W-1:0] rdata
);

  logic [ROW_W-1:0] mem_r [DEPTH];

  // Row storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write to the addressed row is forwarded.
  always_ff @(posedge clk) begin
    rdata <= (we && (waddr == raddr)) ? wdata : mem_r[raddr];
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Reassembles descending-order result rows into N x N matrices (two banks) and
// replays each matrix row 0..N-1 on a valid/ready stream.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_in,
  input  logic [row_w(N_SIZE, DATAWIDTH)-1:0]  row_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [row_w(N_SIZE, DATAWIDTH)-1:0]  out_data,
  output logic [idx_w(N_SIZE)-1:0]             out_row,
  output logic                                 out_last,
  output logic                                 overflow_err,
  output logic [15:0]                          matrix_count
);

  localparam int ROW_W = row_w(N_SIZE, DATAWIDTH);
  localparam int IDX_W = idx_w(N_SIZE);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N_SIZE - 1);

  bank_state_t      state_r [2];
  bank_state_t      state_n [2];
  logic             wr_ptr_r, rd_ptr_r, rd_ptr_n;
  logic [IDX_W-1:0] beat_cnt_r;
  logic             out_valid_r, out_last_r, overflow_r;
  logic [IDX_W-1:0] out_row_r;
  logic [ROW_W-1:0] out_data_r;
  logic [15:0]      matrix_count_r;

  logic             wr_open_s, accept_s, drop_s, fill_done_s, hs_s, last_hs_s;
  logic             valid_n, last_n;
  logic [IDX_W-1:0] row_n;
  logic [ROW_W-1:0] data_n;
  logic [1:0]       we_s;
  logic [IDX_W-1:0] waddr_s;
  logic [IDX_W-1:0] raddr_s [2];
  logic [ROW_W-1:0] rdata_s [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    collector_bank #(
      .ROW_W(ROW_W),
      .DEPTH(N_SIZE),
      .AW   (IDX_W)
    ) u_bank (
      .clk  (clk),
      .we   (we_s[g]),
      .waddr(waddr_s),
      .wdata(row_in),
      .raddr(raddr_s[g]),
      .rdata(rdata_s[g])
    );
  end

  // Capture/drain decisions, bank state transitions and next output row.
  always_comb begin
    wr_open_s   = (state_r[wr_ptr_r] == EMPTY) || (state_r[wr_ptr_r] == FILLING);
    accept_s    = valid_in && wr_open_s;
    drop_s      = valid_in && !wr_open_s;
    fill_done_s = accept_s && (beat_cnt_r == LAST_ROW);
    hs_s        = out_valid_r && out_ready;
    last_hs_s   = hs_s && out_last_r;
    rd_ptr_n    = rd_ptr_r ^ last_hs_s;
    waddr_s     = LAST_ROW - beat_cnt_r;
    we_s        = 2'b00;
    valid_n     = out_valid_r;
    row_n       = out_row_r;
    data_n      = out_data_r;
    state_n     = state_r;

    // The bank being written and the bank finishing a drain are never the same.
    for (int b = 0; b < 2; b++) begin
      if (accept_s && (wr_ptr_r == 1'(b))) begin
        we_s[b]    = 1'b1;
        state_n[b] = fill_done_s ? FULL : FILLING;
      end else if (last_hs_s && (rd_ptr_r == 1'(b))) begin
        we_s[b]    = 1'b0;
        state_n[b] = EMPTY;
      end else begin
        we_s[b]    = 1'b0;
        state_n[b] = state_r[b];
      end
    end

    if (hs_s && !out_last_r) begin
      valid_n = 1'b1;
      row_n   = out_row_r + IDX_W'(1);
      data_n  = rdata_s[rd_ptr_r];
    end else if (out_valid_r && !hs_s) begin
      valid_n = 1'b1;
    end else if (state_r[rd_ptr_n] == FULL) begin
      valid_n           = 1'b1;
      row_n             = '0;
      data_n            = rdata_s[rd_ptr_n];
      state_n[rd_ptr_n] = DRAINING;
    end else if (fill_done_s && (wr_ptr_r == rd_ptr_n)) begin
      // Row 0 is the final beat, so it goes straight to the output register.
      valid_n           = 1'b1;
      row_n             = '0;
      data_n            = row_in;
      state_n[rd_ptr_n] = DRAINING;
    end else begin
      valid_n = 1'b0;
      row_n   = '0;
      data_n  = out_data_r;
    end
    last_n = valid_n && (row_n == LAST_ROW);

    // The bank shown next prefetches the following row; the other bank holds row 0.
    for (int b = 0; b < 2; b++) begin
      raddr_s[b] = (valid_n && (rd_ptr_n == 1'(b)) && (row_n != LAST_ROW)) ?
                   (row_n + IDX_W'(1)) : '0;
    end
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r[0]     <= EMPTY;
      state_r[1]     <= EMPTY;
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      beat_cnt_r     <= '0;
      out_valid_r    <= 1'b0;
      out_last_r     <= 1'b0;
      out_row_r      <= '0;
      out_data_r     <= '0;
      overflow_r     <= 1'b0;
      matrix_count_r <= 16'd0;
    end else begin
      state_r        <= state_n;
      wr_ptr_r       <= wr_ptr_r ^ fill_done_s;
      rd_ptr_r       <= rd_ptr_n;
      beat_cnt_r     <= fill_done_s ? '0 : (accept_s ? beat_cnt_r + IDX_W'(1) : beat_cnt_r);
      out_valid_r    <= valid_n;
      out_last_r     <= last_n;
      out_row_r      <= row_n;
      out_data_r     <= data_n;
      overflow_r     <= overflow_r | drop_s;
      matrix_count_r <= matrix_count_r + 16'(last_hs_s);
    end
  end

  assign out_valid    = out_valid_r;
  assign out_last     = out_last_r;
  assign out_row      = out_row_r;
  assign out_data     = out_data_r;
  assign overflow_err = overflow_r;
  assign matrix_count = matrix_count_r;

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Downstream stage of the systolic array core. Captures the N result rows the array emits on `valid_out` / `matrix_c_out` and reassembles them into one N×N result matrix.
- Replays that matrix row 0 to row N-1 on a valid/ready stream.
- Double-buffered: matrix k+1 can be captured while matrix k drains.
- The array has no backpressure, so lost data is flagged rather than stalled.

Parameters:
- DATAWIDTH, 16: operand width; each result element is 2*DATAWIDTH bits.
- N_SIZE, 5: matrix dimension; N_SIZE rows per matrix and N_SIZE elements per row.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  row beat valid; connects to array `valid_out`.
- row_in  in  N_SIZE*2*DATAWIDTH  result row; connects to array `matrix_c_out`. Element k sits at bits [(N_SIZE-k)*2*DATAWIDTH-1 -: 2*DATAWIDTH] (column 0 in the MSBs).
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accept.
- out_data  out  N_SIZE*2*DATAWIDTH  output row, same element packing as row_in.
- out_row  out  $clog2(N_SIZE)  row index of out_data.
- out_last  out  1  high with row N_SIZE-1 of a matrix.
- overflow_err  out  1  sticky: a beat was dropped.
- matrix_count  out  16  matrices fully drained, wraps modulo 2^16.

Behaviour:
- Reset (rst high at posedge), whatever is in flight:
  - both banks EMPTY, write and read bank pointers = 0, beat and drain counters = 0.
  - out_valid=0, out_last=0, out_row=0, out_data=0, overflow_err=0, matrix_count=0.
  - A partial matrix is discarded.
- Input ordering:
  - The array emits rows in descending index, so beat b (0-based) of a matrix is row N_SIZE-1-b.
  - The collector writes beat b to row N_SIZE-1-b of the write bank.
  - Beats need not be contiguous; an idle cycle holds the beat counter.
- Bank states (per bank): EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING: on the first beat accepted into the write bank.
  - FILLING -> FULL: when the Nth beat is written. Write pointer then toggles; beat counter clears.
  - FULL -> DRAINING: when the bank becomes the read bank and out_valid rises.
  - DRAINING -> EMPTY: on the handshake of row N_SIZE-1. Read pointer toggles; matrix_count increments.
- Capture rule:
  - A beat is accepted only if the write bank is EMPTY or FILLING.
  - Otherwise the beat is dropped and overflow_err is set. It stays set until rst.
  - A bank freed by a drain in cycle t is writable from cycle t+1. A beat arriving at cycle t while that bank is still FULL/DRAINING is dropped.
- Output timing:
  - out_valid rises the cycle after the Nth beat is written, if the read bank is FULL.
  - out_data, out_row and out_last are registered and stable while out_valid=1 and out_ready=0.
  - A handshake (out_valid & out_ready) advances to the next row the following cycle. This gives one row per cycle with out_ready held high.
  - After the last row's handshake:
    - if the other bank is FULL, out_valid stays high and row 0 of that bank appears the next cycle (no bubble);
    - otherwise out_valid drops.
- Simultaneous events:
  - Capture into one bank and drain of the other in the same cycle is fully supported.
  - Completing a fill and completing a drain in the same cycle are both applied.
- Arithmetic: no modification of data. Data width in equals data width out. matrix_count wraps 0xFFFF -> 0.
- N_SIZE=1:
  - every beat completes a matrix;
  - out_row is 1 bit wide and held at 0;
  - out_last is always 1 when out_valid=1.

Decomposition:
- Package systolic_pkg:
  - bank_state_t enum {EMPTY, FILLING, FULL, DRAINING};
  - localparams ROW_W = N_SIZE*2*DATAWIDTH and IDX_W = max(1, $clog2(N_SIZE)), both as functions of the parameters;
  - a shared element-slice function giving the MSB-first packing.
- Sub-module collector_bank:
  - one N_SIZE×ROW_W register file, one write port (we, waddr, wdata) and one registered read port (raddr, rdata);
  - instantiated twice.
- The top level holds the two state registers, the pointers, the counters and the output register.

Test Plan (N_SIZE=3, DATAWIDTH=8, out_ready=1 unless noted):
- Single matrix:
  - Stimulus: beats {7,8,9}, {4,5,6}, {1,2,3} on consecutive cycles.
  - Response: starting the cycle after beat 3, rows {1,2,3}/row0, {4,5,6}/row1, {7,8,9}/row2 with out_last=1 on row2. matrix_count=1, overflow_err=0.
- Gapped input:
  - Stimulus: same beats with 2 idle cycles between them.
  - Response: identical output and ordering; out_valid stays low until the third beat has been written.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises.
  - Response: out_data={1,2,3} and out_row=0 are held unchanged; the drain resumes on release.
- Back-to-back:
  - Stimulus: two matrices of 3 beats each, continuous, with out_ready=1.
  - Response: 6 output rows with no bubble between matrices; matrix_count=2.
- Overflow:
  - Stimulus: out_ready=0 while 3 matrices (9 beats) arrive.
  - Response: the first two matrices are kept and all beats of the third are dropped; overflow_err=1.
  - Then set out_ready=1: exactly 6 rows appear, and overflow_err stays 1.
- Reset mid-operation:
  - Stimulus: assert rst after 2 beats of matrix 2 while matrix 1 is draining.
  - Response: next cycle all outputs are 0. A fresh 3-beat matrix afterwards drains correctly with matrix_count=1.
